// File: rtl/mac32_dot_seq.sv
// mac32_dot_seq: sequential FP32 dot product over LEN element pairs, built
// around one combinational fused multiply-add (MAC32_top, defined below).
// Optional feature: define MAC32_DOT_INIT_C_EN to add port Init_i, the FP32
// addend used for the first element of each vector (otherwise +0).
module mac32_dot_seq #(
  parameter int LEN = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  Rounding_mode_i,
  input  logic        In_valid_i,
  output logic        In_ready_o,
  input  logic [31:0] A_i,
  input  logic [31:0] B_i,
`ifdef MAC32_DOT_INIT_C_EN
  input  logic [31:0] Init_i,
`endif
  output logic        Out_valid_o,
  input  logic        Out_ready_i,
  output logic [31:0] Result_o,
  output logic        OF_o,
  output logic        UF_o,
  output logic        NX_o,
  output logic        NV_o
);
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic {ACC, OUT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   acc_q, acc_d;
  logic [2:0]    rm_q, rm_d;
  logic [3:0]    flg_q, flg_d;      // {OF, UF, NX, NV}
  logic [31:0]   mac_c, mac_res;
  logic [2:0]    mac_rm;
  logic [3:0]    mac_flg;
  logic          first, last;

  assign first = (cnt_q == '0);
  assign last  = (cnt_q == CW'(LEN - 1));

`ifdef MAC32_DOT_INIT_C_EN
  assign mac_c = first ? Init_i : acc_q;
`else
  assign mac_c = first ? 32'h0000_0000 : acc_q;
`endif
  // Rounding mode is captured with the first pair so mid-vector changes are ignored
  assign mac_rm = first ? Rounding_mode_i : rm_q;

  MAC32_top u_mac (
    .A_i             (A_i),
    .B_i             (B_i),
    .C_i             (mac_c),
    .Rounding_mode_i (mac_rm),
    .Result_o        (mac_res),
    .OF_o            (mac_flg[3]),
    .UF_o            (mac_flg[2]),
    .NX_o            (mac_flg[1]),
    .NV_o            (mac_flg[0])
  );

  // State, counter, accumulator, captured rounding mode and sticky flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACC;
      cnt_q   <= '0;
      acc_q   <= 32'h0000_0000;
      rm_q    <= 3'b000;
      flg_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rm_q    <= rm_d;
      flg_q   <= flg_d;
    end
  end

  // Next state: accumulate pairs in ACC, present the result in OUT
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    rm_d        = rm_q;
    flg_d       = flg_q;
    In_ready_o  = 1'b0;
    Out_valid_o = 1'b0;
    case (state_q)
      ACC: begin
        In_ready_o = 1'b1;
        if (In_valid_i) begin
          acc_d = mac_res;
          flg_d = first ? mac_flg : (flg_q | mac_flg);
          if (first) rm_d = Rounding_mode_i;
          if (last) begin
            cnt_d   = '0;
            state_d = OUT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        Out_valid_o = 1'b1;
        if (Out_ready_i) state_d = ACC;
      end
    endcase
  end

  assign Result_o = acc_q;
  assign OF_o     = flg_q[3];
  assign UF_o     = flg_q[2];
  assign NX_o     = flg_q[1];
  assign NV_o     = flg_q[0];
endmodule

// MAC32_top: combinational FP32 fused A*B+C with a single rounding step.
module MAC32_top (
  input  logic [31:0] A_i,
  input  logic [31:0] B_i,
  input  logic [31:0] C_i,
  input  logic [2:0]  Rounding_mode_i,
  output logic [31:0] Result_o,
  output logic        OF_o,
  output logic        UF_o,
  output logic        NX_o,
  output logic        NV_o
);
  localparam int          FW   = 76;
  localparam logic [31:0] QNAN = 32'h7fc0_0000;

  function automatic logic round_up(input logic [2:0] rm, input logic s,
                                    input logic lsb, input logic g, input logic st);
    case (rm)
      3'b001:  round_up = 1'b0;
      3'b010:  round_up = s & (g | st);
      3'b011:  round_up = ~s & (g | st);
      3'b100:  round_up = g;
      default: round_up = g & (st | lsb);
    endcase
  endfunction

  // Right shift that folds every discarded bit into the LSB
  function automatic logic [FW-1:0] shr_sticky(input logic [FW-1:0] x,
                                               input logic signed [12:0] d);
    logic [FW-1:0] y;
    logic          s;
    if (d >= 13'sd76) begin
      y = '0;
      s = |x;
    end else begin
      y = x >> d[6:0];
      s = |(x & ~({FW{1'b1}} << d[6:0]));
    end
    shr_sticky = {y[FW-1:1], y[0] | s};
  endfunction

  logic [7:0]  ea, eb, ec;
  logic [23:0] ma, mb, mc;
  logic a_inf, b_inf, c_inf, a_nan, b_nan, c_nan, a_snan, b_snan, c_snan, inf_x_zero;

  assign ea = (A_i[30:23] == 8'h00) ? 8'd1 : A_i[30:23];
  assign eb = (B_i[30:23] == 8'h00) ? 8'd1 : B_i[30:23];
  assign ec = (C_i[30:23] == 8'h00) ? 8'd1 : C_i[30:23];
  assign ma = {|A_i[30:23], A_i[22:0]};
  assign mb = {|B_i[30:23], B_i[22:0]};
  assign mc = {|C_i[30:23], C_i[22:0]};
  assign a_inf  = (&A_i[30:23]) & ~(|A_i[22:0]);
  assign b_inf  = (&B_i[30:23]) & ~(|B_i[22:0]);
  assign c_inf  = (&C_i[30:23]) & ~(|C_i[22:0]);
  assign a_nan  = (&A_i[30:23]) & (|A_i[22:0]);
  assign b_nan  = (&B_i[30:23]) & (|B_i[22:0]);
  assign c_nan  = (&C_i[30:23]) & (|C_i[22:0]);
  assign a_snan = a_nan & ~A_i[22];
  assign b_snan = b_nan & ~B_i[22];
  assign c_snan = c_nan & ~C_i[22];
  assign inf_x_zero = (a_inf & ~(|B_i[30:0])) | (b_inf & ~(|A_i[30:0]));

  logic               sp, sc, sr, g, st, inc, sat;
  logic [47:0]        mp;
  logic signed [12:0] hp, hc, hh, ee, lt, dd, fld;
  logic [FW-1:0]      xp, xc;
  logic [FW:0]        sum;
  logic [FW+24:0]     sx;
  logic [24:0]        tx, mr;
  logic [6:0]         q, sh;

  // Align, add, normalise, round, then let special operands override
  always_comb begin
    sp = A_i[31] ^ B_i[31];
    sc = C_i[31];
    mp = {24'b0, ma} * {24'b0, mb};
    // Exponent of the top frame bit; zero operands are pushed far below the other
    hp = (mp == '0) ? -13'sd400 : $signed({5'b0, ea}) + $signed({5'b0, eb}) - 13'sd253;
    hc = (mc == '0) ? -13'sd400 : $signed({5'b0, ec}) - 13'sd127;
    if (hp >= hc) begin
      hh = hp;
      xp = {mp, 28'b0};
      xc = shr_sticky({mc, 52'b0}, hp - hc);
    end else begin
      hh = hc;
      xc = {mc, 52'b0};
      xp = shr_sticky({mp, 28'b0}, hc - hp);
    end
    if (sp == sc) begin
      sum = {1'b0, xp} + {1'b0, xc};
      sr  = sp;
    end else if (xp >= xc) begin
      sum = {1'b0, xp - xc};
      sr  = sp;
    end else begin
      sum = {1'b0, xc - xp};
      sr  = sc;
    end
    q = '0;
    for (int i = 0; i <= FW; i++) if (sum[i]) q = 7'(i);
    ee  = hh - 13'sd75 + $signed({6'b0, q});
    // LSB exponent of the kept mantissa; clamps at the subnormal grid
    lt  = (ee > -13'sd126) ? ee - 13'sd23 : -13'sd149;
    dd  = lt - hh + 13'sd98;
    sh  = (dd > 13'sd127) ? 7'd127 : dd[6:0];
    sx  = {sum, 24'b0};
    tx  = 25'(sx >> sh);
    g   = tx[0];
    st  = |(sx & ~({(FW+25){1'b1}} << sh));
    inc = round_up(Rounding_mode_i, sr, tx[1], g, st);
    mr  = {1'b0, tx[24:1]} + {24'b0, inc};
    fld = mr[24] ? lt + 13'sd151 : (mr[23] ? lt + 13'sd150 : 13'sd0);
    sat = (Rounding_mode_i == 3'b001) | ((Rounding_mode_i == 3'b010) & ~sr) |
          ((Rounding_mode_i == 3'b011) & sr);

    Result_o = 32'h0;
    OF_o = 1'b0;
    UF_o = 1'b0;
    NX_o = 1'b0;
    NV_o = 1'b0;
    if (a_nan | b_nan | c_nan) begin
      Result_o = QNAN;
      NV_o     = a_snan | b_snan | c_snan | inf_x_zero;
    end else if (inf_x_zero) begin
      Result_o = QNAN;
      NV_o     = 1'b1;
    end else if (a_inf | b_inf) begin
      if (c_inf & (sc != sp)) begin
        Result_o = QNAN;
        NV_o     = 1'b1;
      end else begin
        Result_o = {sp, 8'hff, 23'h0};
      end
    end else if (c_inf) begin
      Result_o = C_i;
    end else if (sum == '0) begin
      Result_o = {(sp == sc) ? sp : (Rounding_mode_i == 3'b010), 31'h0};
    end else if (fld >= 13'sd255) begin
      OF_o     = 1'b1;
      NX_o     = 1'b1;
      Result_o = sat ? {sr, 31'h7f7f_ffff} : {sr, 31'h7f80_0000};
    end else begin
      Result_o = {sr, fld[7:0], mr[24] ? mr[23:1] : mr[22:0]};
      NX_o     = g | st;
      UF_o     = (g | st) & (ee < -13'sd126);
    end
  end
endmodule

// File: tb/tb_mac32_dot_seq.sv
// Scoreboard bench for mac32_dot_seq (LEN=4); covers the Init_i addend when
// MAC32_DOT_INIT_C_EN is defined.
module tb_mac32_dot_seq;
  logic        clk = 1'b0;
  logic        rst_i;
  logic [2:0]  Rounding_mode_i;
  logic        In_valid_i, In_ready_o;
  logic [31:0] A_i, B_i;
  logic        Out_valid_o, Out_ready_i;
  logic [31:0] Result_o;
  logic        OF_o, UF_o, NX_o, NV_o;
`ifdef MAC32_DOT_INIT_C_EN
  logic [31:0] Init_i;
`endif
  logic [35:0] obs;
  logic [35:0] sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  localparam logic [127:0] ONES  = {4{32'h3f80_0000}};
  localparam logic [2:0]   RNE   = 3'b000;
  localparam logic [2:0]   RUP   = 3'b011;

  always #5 clk = ~clk;

  assign obs = {Result_o, OF_o, UF_o, NX_o, NV_o};

  mac32_dot_seq #(.LEN(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .Rounding_mode_i (Rounding_mode_i),
    .In_valid_i      (In_valid_i),
    .In_ready_o      (In_ready_o),
    .A_i             (A_i),
    .B_i             (B_i),
`ifdef MAC32_DOT_INIT_C_EN
    .Init_i          (Init_i),
`endif
    .Out_valid_o     (Out_valid_o),
    .Out_ready_i     (Out_ready_i),
    .Result_o        (Result_o),
    .OF_o            (OF_o),
    .UF_o            (UF_o),
    .NX_o            (NX_o),
    .NV_o            (NV_o)
  );

  task automatic check_eq(input string tag, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one pair and hold it until the block accepts it
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    In_valid_i = 1'b1;
    A_i = a;
    B_i = b;
    while (!In_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_ready", 36'(In_ready_o), 36'd1);
    @(posedge clk);
    #1;
  endtask

  // Wait for the result, compare against the scoreboard, stall `hold` cycles, then take it
  task automatic collect(input int hold);
    logic [35:0] exp;
    int n;
    n = 0;
    @(negedge clk);
    while (!Out_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("out_latency", 36'(n), 36'd0);
    check_eq("sb_nonempty", 36'(sb_q.size() != 0), 36'd1);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 36'h0;
    check_eq("result_flags", obs, exp);
    check_eq("ready_in_out", 36'(In_ready_o), 36'd0);
    In_valid_i = 1'b1;
    A_i = 32'h4049_0fdb;
    B_i = 32'h4049_0fdb;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_result", obs, exp);
      check_eq("hold_valid", 36'({Out_valid_o, In_ready_o}), 36'b10);
    end
    Out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    In_valid_i  = 1'b0;
    Out_ready_i = 1'b0;
    check_eq("ready_after_out", 36'(In_ready_o), 36'd1);
  endtask

  task automatic run_vec(input logic [127:0] aa, input logic [127:0] bb,
                         input logic [2:0] rm0, input logic [2:0] rm1,
                         input logic [35:0] exp, input int hold);
    sb_q.push_back(exp);
    Rounding_mode_i = rm0;
    send(aa[127:96], bb[127:96]);
    Rounding_mode_i = rm1;
    send(aa[95:64], bb[95:64]);
    send(aa[63:32], bb[63:32]);
    send(aa[31:0],  bb[31:0]);
    collect(hold);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ctl"}, 36'({In_ready_o, Out_valid_o}), 36'b10);
    check_eq({tag, "_res"}, obs, 36'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    In_valid_i = 1'b0;
    Out_ready_i = 1'b0;
    A_i = '0;
    B_i = '0;
    Rounding_mode_i = RNE;
`ifdef MAC32_DOT_INIT_C_EN
    Init_i = 32'h0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check_idle("reset");

    run_vec(ONES, ONES, RNE, RNE, {32'h4080_0000, 4'b0000}, 0);
    run_vec({32'h4000_0000, 32'h3fc0_0000, 32'h4080_0000, 32'hbf80_0000},
            {32'h4040_0000, 32'hc000_0000, 32'h3e80_0000, 32'h3f00_0000},
            RNE, RNE, {32'h4060_0000, 4'b0000}, 0);
    run_vec(ONES, ONES, RNE, RNE, {32'h4080_0000, 4'b0000}, 5);
    run_vec({32'h7f80_0000, ONES[95:0]}, {32'h0, ONES[95:0]},
            RNE, RNE, {32'h7fc0_0000, 4'b0001}, 0);
    run_vec({32'h7f7f_ffff, ONES[95:0]}, {32'h4000_0000, ONES[95:0]},
            RNE, RNE, {32'h7f80_0000, 4'b1010}, 2);
    run_vec(ONES, ONES, RNE, RNE, {32'h4080_0000, 4'b0000}, 0);
    run_vec({32'h3f80_0000, 32'h3380_0000, 64'h0}, {32'h3f80_0000, 32'h3f80_0000, 64'h0},
            RNE, RUP, {32'h3f80_0000, 4'b0010}, 0);
    run_vec({32'h3f80_0000, 32'h3380_0000, 64'h0}, {32'h3f80_0000, 32'h3f80_0000, 64'h0},
            RUP, RNE, {32'h3f80_0001, 4'b0010}, 1);

    // Reset after two accepts discards the partial sum
    Rounding_mode_i = RNE;
    send(32'h4000_0000, 32'h4000_0000);
    send(32'h4000_0000, 32'h4000_0000);
    In_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_idle("rst_mid");
    run_vec(ONES, ONES, RNE, RUP, {32'h4080_0000, 4'b0000}, 0);

    // Reset while a result is pending drops it
    send(32'h7f7f_ffff, 32'h4000_0000);
    send(32'h3f80_0000, 32'h3f80_0000);
    send(32'h3f80_0000, 32'h3f80_0000);
    send(32'h3f80_0000, 32'h3f80_0000);
    In_valid_i = 1'b0;
    @(negedge clk);
    check_eq("pending_out", 36'(Out_valid_o), 36'd1);
    check_eq("pending_res", obs, {32'h7f80_0000, 4'b1010});
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_idle("rst_out");
    run_vec(ONES, ONES, RNE, RNE, {32'h4080_0000, 4'b0000}, 0);

`ifdef MAC32_DOT_INIT_C_EN
    Init_i = 32'h3f80_0000;
    run_vec(ONES, ONES, RNE, RNE, {32'h40a0_0000, 4'b0000}, 0);
    Init_i = 32'h0;
`endif
    check_eq("sb_drained", 36'(sb_q.size()), 36'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mac32_dot_seq.md
MAC32_DOT_SEQ -- requirements
Module: mac32_dot_seq

Interface
REQ-001 SHALL have parameter LEN, default 4, meaning element pairs per dot product (legal 1..256).
REQ-002 SHALL have port clk_i  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Rounding_mode_i  input  3  RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100.
REQ-005 SHALL have port In_valid_i  input  1  A_i/B_i pair valid.
REQ-006 SHALL have port In_ready_o  output  1  block accepts a pair.
REQ-007 SHALL have ports A_i, B_i  input  32 each  FP32 multiplicand and multiplier.
REQ-008 SHALL have port Out_valid_o  output  1  dot-product result valid.
REQ-009 SHALL have port Out_ready_i  input  1  consumer accepts the result.
REQ-010 SHALL have port Result_o  output  32  FP32 dot product.
REQ-011 SHALL have ports OF_o, UF_o, NX_o, NV_o  output  1 each  sticky IEEE flags for the vector.

Function
REQ-012 SHALL instantiate one combinational MAC32_top, driving A_i, B_i, C_i and Rounding_mode_i from this block and capturing Result_o and the four flags.
REQ-013 SHALL implement a two-state FSM: ACC (In_ready_o=1, Out_valid_o=0) and OUT (In_ready_o=0, Out_valid_o=1).
REQ-014 SHALL accept a pair only when In_valid_i and In_ready_o are both 1 in the same cycle.
REQ-015 SHALL hold an element counter cnt (width clog2(LEN), minimum 1 bit) that is 0 at the start of each vector.
REQ-016 SHALL drive MAC C_i with 32'h00000000 when cnt==0, and with the accumulator register otherwise.
REQ-017 SHALL, when cnt==0, drive MAC rounding mode directly from Rounding_mode_i and latch it into rm_q on acceptance; for cnt>0 it SHALL use rm_q, so mid-vector changes are ignored.
REQ-018 SHALL, on each accept, load the accumulator with MAC Result_o, OR the MAC flags into the sticky flags (flags replaced, not ORed, when cnt==0), and increment cnt.
REQ-019 SHALL, on the accept with cnt==LEN-1, clear cnt and enter OUT; Out_valid_o SHALL rise the next cycle (latency 1 cycle after the final accept).
REQ-020 SHALL, in OUT, hold Result_o equal to the accumulator and the flags stable until Out_ready_i=1, then return to ACC in the next cycle.
REQ-021 SHALL ignore In_valid_i while in OUT and SHALL ignore Out_ready_i while in ACC.
REQ-022 SHALL, when LEN=1, go ACC->OUT on every accept; minimum throughput is one vector per LEN+1 cycles.
REQ-023 SHALL propagate NaN, infinity and flag semantics exactly as MAC32_top produces them; it SHALL NOT add or mask any flags.

Reset
REQ-024 SHALL, while rst_i=1 at a clock edge, set state=ACC, cnt=0, accumulator=32'h00000000, rm_q=000, and all flags=0.
REQ-025 SHALL output In_ready_o=1, Out_valid_o=0 and Result_o=32'h00000000 after reset; reset mid-vector or in OUT SHALL discard the partial or pending result.

Configuration
REQ-026 SHALL recognise macro MAC32_DOT_INIT_C_EN; when it is defined, the block SHALL add port Init_i (input, 32 bits, FP32 initial addend), and C_i SHALL equal Init_i when cnt==0.
REQ-027 SHALL, when MAC32_DOT_INIT_C_EN is undefined, have no Init_i port and use C_i=32'h00000000 when cnt==0.

Verification
REQ-028 SHALL cover: LEN=4, RNE, four pairs 3f800000 x 3f800000 back-to-back -> Result_o=40800000, all flags 0, Out_valid_o high the cycle after the 4th accept.
REQ-029 SHALL cover: hold Out_ready_i=0 for 5 cycles in OUT -> Out_valid_o=1, In_ready_o=0, Result_o and flags stable, and no pair accepted despite In_valid_i=1.
REQ-030 SHALL cover: first pair 7f800000 x 00000000, then three pairs of 1.0 -> Result_o=7fc00000, NV_o=1.
REQ-031 SHALL cover: first pair 7f7fffff x 40000000 in RNE, then three pairs of 1.0 -> Result_o=7f800000, OF_o=1, NX_o=1; a second vector of 1.0s gives 40800000 with all flags 0.
REQ-032 SHALL cover: rst_i pulsed for one cycle after 2 accepts, then four pairs of 1.0 -> Result_o=40800000; and Rounding_mode_i changed to RUP mid-vector -> result unchanged.
REQ-033 SHALL cover, with MAC32_DOT_INIT_C_EN defined: Init_i=3f800000 plus four pairs of 1.0 -> Result_o=40a00000.
